alu_serial: RTL



---
 rtl/alu_serial.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_serial.sv
// Digit-serial ADD/AND/OR/XOR ALU: one WIDTH-bit op in WIDTH/SLICE beats, with a
// registered inter-slice carry and carry/zero flags for chaining multi-word math.
module alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_zero,
  input  logic             b_inv,
  input  logic             y,
  input  logic             use_carry,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             zero,
  output logic             overflow,
  output logic             c_flag
);
  localparam int BEATS = WIDTH / SLICE;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_AND, OP_OR, OP_XOR} op_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_t              op;
    logic             use_carry;
  } req_t;

  state_t           state;
  req_t             req;
  logic             carry_r;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] acc;
  logic             z_flag;

  logic [WIDTH-1:0] b_pre;
  logic [SLICE-1:0] a_k, b_k, res_k;
  logic [SLICE:0]   sum_k;
  logic [WIDTH-1:0] res_nxt;
  logic             c_nxt, ov_nxt, zero_nxt, last_beat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign b_pre     = b_inv ? ~(b_zero ? '0 : b) : (b_zero ? '0 : b);
  assign last_beat = (k == KW'(BEATS - 1));

  // Slice k datapath; res_nxt is the accumulated result with slice k filled in.
  always_comb begin
    a_k     = req.a[int'(k)*SLICE +: SLICE];
    b_k     = req.b[int'(k)*SLICE +: SLICE];
    sum_k   = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry_r};
    res_k   = sum_k[SLICE-1:0];
    unique case (req.op)
      OP_ADD: res_k = sum_k[SLICE-1:0];
      OP_AND: res_k = a_k & b_k;
      OP_OR:  res_k = a_k | b_k;
      OP_XOR: res_k = a_k ^ b_k;
    endcase
    res_nxt = acc;
    res_nxt[int'(k)*SLICE +: SLICE] = res_k;
    c_nxt    = (req.op == OP_ADD) && sum_k[SLICE];
    ov_nxt   = (req.op == OP_ADD) && (req.a[MSB] == req.b[MSB]) &&
               (res_nxt[MSB] != req.a[MSB]);
    zero_nxt = (res_nxt == '0) && (req.use_carry ? z_flag : 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= '0;
      carry_r  <= 1'b0;
      k        <= '0;
      acc      <= '0;
      s        <= '0;
      c        <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          req     <= '{a: a, b: b_pre, op: op_t'(op), use_carry: use_carry};
          carry_r <= use_carry ? c_flag : y;
          k       <= '0;
          acc     <= '0;
          state   <= BUSY;
        end
        BUSY: begin
          acc     <= res_nxt;
          carry_r <= sum_k[SLICE];
          if (last_beat) begin
            // Flags change only here, so a chained op accepted later sees this result.
            k        <= '0;
            s        <= res_nxt;
            c        <= c_nxt;
            overflow <= ov_nxt;
            zero     <= zero_nxt;
            c_flag   <= c_nxt;
            z_flag   <= zero_nxt;
            state    <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
